// File: rtl/a23_copro_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : a23_copro_pkg
//  Purpose  : CP15 operation encodings, register indices and the request
//             legality check shared by the coprocessor and its master.
//  Revision : 1.0 - initial release
// ============================================================================
package a23_copro_pkg;

    localparam logic [1:0] c_OP_IDLE = 2'd0;
    localparam logic [1:0] c_OP_MRC  = 2'd1;
    localparam logic [1:0] c_OP_MCR  = 2'd2;

    localparam logic [3:0] c_CP15_NUM = 4'd15;

    localparam logic [3:0] c_CRN_ID            = 4'd0;
    localparam logic [3:0] c_CRN_CACHE_FLUSH   = 4'd1;
    localparam logic [3:0] c_CRN_CACHE_CTRL    = 4'd2;
    localparam logic [3:0] c_CRN_CACHEABLE     = 4'd3;
    localparam logic [3:0] c_CRN_UPDATEABLE    = 4'd4;
    localparam logic [3:0] c_CRN_DISRUPTIVE    = 4'd5;
    localparam logic [3:0] c_CRN_FAULT_STATUS  = 4'd6;
    localparam logic [3:0] c_CRN_FAULT_ADDRESS = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } copro_state_t;

    // Register 1 is a write-only flush trigger; 6 and 7 are read-only fault info.
    function automatic logic copro_req_supported(input logic write, input logic [3:0] crn);
        if (write) begin
            return (crn >= c_CRN_CACHE_FLUSH) && (crn <= c_CRN_DISRUPTIVE);
        end
        return (crn == c_CRN_ID) ||
               ((crn >= c_CRN_CACHE_CTRL) && (crn <= c_CRN_FAULT_ADDRESS));
    endfunction

endpackage
`default_nettype wire

// File: rtl/a23_copro_master.sv
`default_nettype none
// ============================================================================
//  Module   : a23_copro_master
//  Purpose  : Turns single valid/ready host requests into one sampled CP15
//             MRC/MCR operation and returns a valid/ready response.
//  Revision : 1.0 - initial release
// ============================================================================
module a23_copro_master
    import a23_copro_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [3:0]  i_req_crn,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    input  logic        i_fetch_stall,
    output logic [1:0]  o_copro_operation,
    output logic [3:0]  o_copro_crn,
    output logic [3:0]  o_copro_crm,
    output logic [2:0]  o_copro_opcode1,
    output logic [2:0]  o_copro_opcode2,
    output logic [3:0]  o_copro_num,
    output logic [31:0] o_copro_write_data,
    input  logic [31:0] i_copro_read_data
);

    copro_state_t r_state_q,       w_state_d;
    logic         r_req_ready_q,   w_req_ready_d;
    logic         r_rsp_valid_q,   w_rsp_valid_d;
    logic         r_rsp_err_q,     w_rsp_err_d;
    logic [31:0]  r_rsp_rdata_q,   w_rsp_rdata_d;
    logic [1:0]   r_op_q,          w_op_d;
    logic [3:0]   r_crn_q,         w_crn_d;
    logic [31:0]  r_wdata_q,       w_wdata_d;
    logic         r_write_q,       w_write_d;

    always_comb begin
        w_state_d     = r_state_q;
        w_req_ready_d = r_req_ready_q;
        w_rsp_valid_d = r_rsp_valid_q;
        w_rsp_err_d   = r_rsp_err_q;
        w_rsp_rdata_d = r_rsp_rdata_q;
        w_op_d        = r_op_q;
        w_crn_d       = r_crn_q;
        w_wdata_d     = r_wdata_q;
        w_write_d     = r_write_q;

        case (r_state_q)
            ST_IDLE: begin
                if (i_req_valid && r_req_ready_q) begin
                    w_req_ready_d = 1'b0;
                    w_write_d     = i_req_write;
                    w_crn_d       = i_req_crn;
                    w_wdata_d     = i_req_wdata;
                    if (copro_req_supported(i_req_write, i_req_crn)) begin
                        w_state_d = ST_ISSUE;
                        w_op_d    = i_req_write ? c_OP_MCR : c_OP_MRC;
                    end else begin
                        // Rejected requests never reach the coprocessor.
                        w_state_d     = ST_RESP;
                        w_rsp_valid_d = 1'b1;
                        w_rsp_err_d   = 1'b1;
                        w_rsp_rdata_d = 32'd0;
                    end
                end
            end

            ST_ISSUE: begin
                // The coprocessor only samples on an unstalled edge, so hold until then.
                if (!i_fetch_stall) begin
                    w_op_d = c_OP_IDLE;
                    if (r_write_q) begin
                        w_state_d     = ST_RESP;
                        w_rsp_valid_d = 1'b1;
                        w_rsp_err_d   = 1'b0;
                        w_rsp_rdata_d = 32'd0;
                    end else begin
                        w_state_d = ST_CAPTURE;
                    end
                end
            end

            ST_CAPTURE: begin
                w_state_d     = ST_RESP;
                w_rsp_valid_d = 1'b1;
                w_rsp_err_d   = 1'b0;
                w_rsp_rdata_d = i_copro_read_data;
            end

            ST_RESP: begin
                if (i_rsp_ready) begin
                    w_state_d     = ST_IDLE;
                    w_req_ready_d = 1'b1;
                    w_rsp_valid_d = 1'b0;
                    w_rsp_err_d   = 1'b0;
                    w_rsp_rdata_d = 32'd0;
                end
            end

            default: begin
                w_state_d     = ST_IDLE;
                w_req_ready_d = 1'b1;
                w_rsp_valid_d = 1'b0;
                w_op_d        = c_OP_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state_q     <= ST_IDLE;
            r_req_ready_q <= 1'b1;
            r_rsp_valid_q <= 1'b0;
            r_rsp_err_q   <= 1'b0;
            r_rsp_rdata_q <= 32'd0;
            r_op_q        <= c_OP_IDLE;
            r_crn_q       <= 4'd0;
            r_wdata_q     <= 32'd0;
            r_write_q     <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_req_ready_q <= w_req_ready_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_err_q   <= w_rsp_err_d;
            r_rsp_rdata_q <= w_rsp_rdata_d;
            r_op_q        <= w_op_d;
            r_crn_q       <= w_crn_d;
            r_wdata_q     <= w_wdata_d;
            r_write_q     <= w_write_d;
        end
    end

    assign o_req_ready        = r_req_ready_q;
    assign o_rsp_valid        = r_rsp_valid_q;
    assign o_rsp_err          = r_rsp_err_q;
    assign o_rsp_rdata        = r_rsp_rdata_q;
    assign o_copro_operation  = r_op_q;
    assign o_copro_crn        = r_crn_q;
    assign o_copro_write_data = r_wdata_q;
    assign o_copro_crm        = 4'd0;
    assign o_copro_opcode1    = 3'd0;
    assign o_copro_opcode2    = 3'd0;
    assign o_copro_num        = c_CP15_NUM;

endmodule
`default_nettype wire

// File: tb/tb_a23_copro_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_a23_copro_master
//  Purpose  : Bench for a23_copro_master with a small CP15 coprocessor model
//             and a queue of expected responses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_a23_copro_master;
    import a23_copro_pkg::*;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_write = 1'b0;
    logic [3:0]  i_req_crn = 4'd0;
    logic [31:0] i_req_wdata = 32'd0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b1;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        i_fetch_stall = 1'b0;
    logic [1:0]  o_copro_operation;
    logic [3:0]  o_copro_crn;
    logic [3:0]  o_copro_crm;
    logic [2:0]  o_copro_opcode1;
    logic [2:0]  o_copro_opcode2;
    logic [3:0]  o_copro_num;
    logic [31:0] o_copro_write_data;
    logic [31:0] i_copro_read_data;

    a23_copro_master dut (
        .i_clk              (clk),
        .i_rst              (i_rst),
        .i_req_valid        (i_req_valid),
        .o_req_ready        (o_req_ready),
        .i_req_write        (i_req_write),
        .i_req_crn          (i_req_crn),
        .i_req_wdata        (i_req_wdata),
        .o_rsp_valid        (o_rsp_valid),
        .i_rsp_ready        (i_rsp_ready),
        .o_rsp_rdata        (o_rsp_rdata),
        .o_rsp_err          (o_rsp_err),
        .i_fetch_stall      (i_fetch_stall),
        .o_copro_operation  (o_copro_operation),
        .o_copro_crn        (o_copro_crn),
        .o_copro_crm        (o_copro_crm),
        .o_copro_opcode1    (o_copro_opcode1),
        .o_copro_opcode2    (o_copro_opcode2),
        .o_copro_num        (o_copro_num),
        .o_copro_write_data (o_copro_write_data),
        .i_copro_read_data  (i_copro_read_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          mrc_seen = 0;
    int          mcr_seen = 0;
    logic [3:0]  last_mcr_crn = 4'd0;
    logic [31:0] last_mcr_wdata = 32'd0;
    logic [31:0] cp_regs [0:7];
    logic [31:0] cp_rdata = 32'd0;
    logic [31:0] shadow [0:7];

    function automatic logic [31:0] init_val(input int idx);
        return (idx == 0) ? 32'h4156_0300 : (32'h0C0D_0000 | 32'(idx));
    endfunction

    function automatic logic ref_supported(input logic wr, input logic [3:0] crn);
        if (wr) return (crn == 4'd1) || (crn == 4'd2) || (crn == 4'd3) || (crn == 4'd4) || (crn == 4'd5);
        return (crn == 4'd0) || (crn == 4'd2) || (crn == 4'd3) || (crn == 4'd4) ||
               (crn == 4'd5) || (crn == 4'd6) || (crn == 4'd7);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Coprocessor model: samples only on unstalled edges, read data registered.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 8; i++) cp_regs[i] <= init_val(i);
        end else if (!i_fetch_stall) begin
            if (o_copro_operation == 2'd2 && o_copro_crn >= 4'd2 && o_copro_crn <= 4'd5)
                cp_regs[o_copro_crn[2:0]] <= o_copro_write_data;
            if (o_copro_operation == 2'd1)
                cp_rdata <= (o_copro_crn < 4'd8) ? cp_regs[o_copro_crn[2:0]] : 32'd0;
        end
    end
    assign i_copro_read_data = cp_rdata;

    always @(negedge clk) begin
        if (!i_rst) begin
            if (o_copro_operation == 2'd1) mrc_seen <= mrc_seen + 1;
            if (o_copro_operation == 2'd2) begin
                mcr_seen       <= mcr_seen + 1;
                last_mcr_crn   <= o_copro_crn;
                last_mcr_wdata <= o_copro_write_data;
            end
        end
    end

    // One request/response transaction; lat is -1 if the DUT never answered.
    task automatic run_req(input logic wr, input logic [3:0] crn, input logic [31:0] wd,
                           input int stall_n, input int hold, output int lat);
        exp_t        e;
        exp_t        got;
        logic        sup;
        int          t0;
        logic [31:0] held;
        sup     = ref_supported(wr, crn);
        e.err   = !sup;
        e.rdata = (sup && !wr) ? shadow[crn[2:0]] : 32'd0;
        if (sup && wr && crn >= 4'd2 && crn <= 4'd5) shadow[crn[2:0]] = wd;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_req_ready) break;
        end
        if (!o_req_ready) begin
            checks++; failures++;
            $display("FAIL req_ready_timeout crn=%0d got=0 want=1", crn);
            return;
        end
        exp_q.push_back(e);
        i_req_valid   = 1'b1;
        i_req_write   = wr;
        i_req_crn     = crn;
        i_req_wdata   = wd;
        i_fetch_stall = (stall_n > 0);
        i_rsp_ready   = (hold == 0);
        t0 = cyc;
        @(posedge clk);
        #1 i_req_valid = 1'b0;
        if (stall_n > 0) begin
            repeat (stall_n) @(posedge clk);
            #1 i_fetch_stall = 1'b0;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_rsp_valid) break;
        end
        if (!o_rsp_valid) begin
            checks++; failures++;
            $display("FAIL rsp_timeout crn=%0d write=%0d got=no_response want=response", crn, wr);
            exp_q.delete();
            i_rsp_ready = 1'b1;
            return;
        end
        lat  = cyc - t0;
        held = o_rsp_rdata;
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            checks++;
            if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== held || o_req_ready !== 1'b0) begin
                failures++;
                $display("FAIL rsp_hold got valid=%b rdata=%h ready=%b want valid=1 rdata=%h ready=0",
                         o_rsp_valid, o_rsp_rdata, o_req_ready, held);
            end
            @(posedge clk);
            #1 i_rsp_ready = 1'b1;
            @(negedge clk);
        end
        got = exp_q.pop_front();
        checks++;
        if (o_rsp_err !== got.err || o_rsp_rdata !== got.rdata) begin
            failures++;
            $display("FAIL scoreboard crn=%0d write=%0d got err=%b rdata=%h want err=%b rdata=%h",
                     crn, wr, o_rsp_err, o_rsp_rdata, got.err, got.rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++; if (o_req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b want=1", o_req_ready); end
        checks++; if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", o_rsp_valid); end
        checks++; if (o_rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b want=0", o_rsp_err); end
        checks++; if (o_rsp_rdata !== 32'd0) begin failures++; $display("FAIL reset_rsp_rdata got=%h want=0", o_rsp_rdata); end
        checks++; if (o_copro_operation !== 2'd0) begin failures++; $display("FAIL reset_operation got=%0d want=0", o_copro_operation); end
        checks++; if (o_copro_crn !== 4'd0) begin failures++; $display("FAIL reset_crn got=%0d want=0", o_copro_crn); end
        checks++; if (o_copro_write_data !== 32'd0) begin failures++; $display("FAIL reset_wdata got=%h want=0", o_copro_write_data); end
        checks++;
        if (o_copro_crm !== 4'd0 || o_copro_opcode1 !== 3'd0 || o_copro_opcode2 !== 3'd0 || o_copro_num !== 4'd15) begin
            failures++;
            $display("FAIL const_fields got crm=%0d op1=%0d op2=%0d num=%0d want 0 0 0 15",
                     o_copro_crm, o_copro_opcode1, o_copro_opcode2, o_copro_num);
        end
        @(negedge clk);
        i_rst = 1'b0;
    endtask

    task automatic test_read_id();
        int lat, m0, c0;
        m0 = mrc_seen; c0 = mcr_seen;
        run_req(1'b0, 4'd0, 32'd0, 0, 0, lat);
        checks++; if (lat != 3) begin failures++; $display("FAIL read_id_latency got=%0d want=3", lat); end
        checks++; if (mrc_seen - m0 != 1 || mcr_seen != c0) begin
            failures++; $display("FAIL read_id_ops got mrc=%0d mcr=%0d want 1 0", mrc_seen - m0, mcr_seen - c0); end
    endtask

    task automatic test_write_read();
        int lat, c0;
        c0 = mcr_seen;
        run_req(1'b1, 4'd3, 32'h0000_00F0, 0, 0, lat);
        checks++; if (lat != 2) begin failures++; $display("FAIL write3_latency got=%0d want=2", lat); end
        checks++; if (mcr_seen - c0 != 1) begin failures++; $display("FAIL write3_mcr_cycles got=%0d want=1", mcr_seen - c0); end
        checks++; if (last_mcr_crn !== 4'd3 || last_mcr_wdata !== 32'h0000_00F0) begin
            failures++; $display("FAIL write3_bus got crn=%0d wdata=%h want 3 000000f0", last_mcr_crn, last_mcr_wdata); end
        run_req(1'b0, 4'd3, 32'd0, 0, 0, lat);
        checks++; if (lat != 3) begin failures++; $display("FAIL read3_latency got=%0d want=3", lat); end
    endtask

    task automatic test_cache_flush();
        int lat, c0;
        c0 = mcr_seen;
        run_req(1'b1, 4'd1, 32'h0000_0001, 0, 0, lat);
        checks++; if (mcr_seen - c0 != 1 || last_mcr_crn !== 4'd1) begin
            failures++; $display("FAIL flush_pulse got cycles=%0d crn=%0d want 1 1", mcr_seen - c0, last_mcr_crn); end
        checks++; if (lat != 2) begin failures++; $display("FAIL flush_latency got=%0d want=2", lat); end
    endtask

    task automatic test_stall();
        int lat, m0;
        m0 = mrc_seen;
        run_req(1'b0, 4'd7, 32'd0, 4, 0, lat);
        checks++; if (mrc_seen - m0 != 5) begin failures++; $display("FAIL stall_op_cycles got=%0d want=5", mrc_seen - m0); end
        checks++; if (lat != 7) begin failures++; $display("FAIL stall_latency got=%0d want=7", lat); end
    endtask

    task automatic test_errors();
        int lat, m0, c0;
        m0 = mrc_seen; c0 = mcr_seen;
        run_req(1'b1, 4'd0, 32'h1234_5678, 0, 0, lat);
        checks++; if (lat != 1) begin failures++; $display("FAIL err_write0_latency got=%0d want=1", lat); end
        run_req(1'b0, 4'd9, 32'd0, 0, 0, lat);
        checks++; if (lat != 1) begin failures++; $display("FAIL err_read9_latency got=%0d want=1", lat); end
        checks++; if (mrc_seen != m0 || mcr_seen != c0) begin
            failures++; $display("FAIL err_no_ops got mrc=%0d mcr=%0d want 0 0", mrc_seen - m0, mcr_seen - c0); end
    endtask

    task automatic test_backpressure();
        int lat;
        run_req(1'b0, 4'd4, 32'd0, 0, 3, lat);
        checks++; if (lat != 3) begin failures++; $display("FAIL bp_latency got=%0d want=3", lat); end
        checks++; if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release got valid=%b ready=%b want 0 1", o_rsp_valid, o_req_ready); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   lat;
        logic quiet;
        e.err = 1'b0; e.rdata = shadow[2];
        @(negedge clk);
        exp_q.push_back(e);
        i_req_valid = 1'b1; i_req_write = 1'b0; i_req_crn = 4'd2; i_req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1 i_req_valid = 1'b0;
        @(posedge clk);
        #1 i_rst = 1'b1;
        #1;
        checks++;
        if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_rsp_err !== 1'b0 || o_rsp_rdata !== 32'd0 ||
            o_copro_operation !== 2'd0 || o_copro_crn !== 4'd0 || o_copro_write_data !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs got ready=%b valid=%b err=%b rdata=%h op=%0d crn=%0d wdata=%h want 1 0 0 0 0 0 0",
                     o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata, o_copro_operation, o_copro_crn, o_copro_write_data);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (o_rsp_valid !== 1'b0 || o_copro_operation !== 2'd0 || o_req_ready !== 1'b1) quiet = 1'b0;
        end
        checks++; if (!quiet) begin failures++; $display("FAIL post_reset_quiet got=activity want=idle"); end
        run_req(1'b0, 4'd2, 32'd0, 0, 0, lat);
        checks++; if (lat != 3) begin failures++; $display("FAIL post_reset_read_latency got=%0d want=3", lat); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] crns [0:8] = '{4'd2, 4'd2, 4'd5, 4'd5, 4'd6, 4'd7, 4'd4, 4'd4, 4'd13};
        logic       wrs  [0:8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int lat, stall_n, want;
        logic sup;
        for (int k = 0; k < 9; k++) begin
            sup     = ref_supported(wrs[k], crns[k]);
            stall_n = sup ? int'($urandom_range(0, 2)) : 0;
            want    = sup ? ((wrs[k] ? 2 : 3) + stall_n) : 1;
            run_req(wrs[k], crns[k], $urandom, stall_n, 0, lat);
            checks++;
            if (lat != want) begin
                failures++;
                $display("FAIL b2b_latency idx=%0d got=%0d want=%0d", k, lat, want);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) shadow[i] = init_val(i);
        test_reset();
        test_read_id();
        test_write_read();
        test_cache_flush();
        test_stall();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
